jtag_tap_controller: RTL

IEEE 1149.1-style TAP controller sequencing the boundary-scan chain of input/output cells. It decodes TMS into the 16-state TAP FSM, holds the instruction register, and contains the BYPASS and IDCODE data registers. It drives CaptureDR/ShiftDR/UpdateDR/TestMode to the chain and muxes the selected register onto TDO. It sits between the chip JTAG pins and the first/last boundary-scan cells.

---
 rtl/jtag_pkg.sv | 44 ++++
 rtl/jtag_tap_controller_if.sv | 26 ++
 rtl/jtag_tap_fsm.sv | 56 +++++
 rtl/jtag_tap_controller.sv | 105 ++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, default opcodes, ID register width and
// the state-decode bundle passed from the FSM to the register datapath.
package jtag_pkg;

  localparam int unsigned IDCODE_W     = 32;
  localparam int unsigned DEF_IR_WIDTH = 4;

  localparam logic [IDCODE_W-1:0] DEF_IDCODE = 32'h1000_0001;

  localparam logic [3:0] DEF_OP_EXTEST = 4'b0000;
  localparam logic [3:0] DEF_OP_SAMPLE = 4'b0001;
  localparam logic [3:0] DEF_OP_IDCODE = 4'b0010;
  localparam logic [3:0] DEF_OP_BYPASS = 4'b1111;

  typedef logic [3:0] tap_state_t;

  localparam tap_state_t TLR      = 4'hF;
  localparam tap_state_t RTI      = 4'hC;
  localparam tap_state_t SEL_DR   = 4'h7;
  localparam tap_state_t CAP_DR   = 4'h6;
  localparam tap_state_t SHIFT_DR = 4'h2;
  localparam tap_state_t EXIT1_DR = 4'h1;
  localparam tap_state_t PAUSE_DR = 4'h3;
  localparam tap_state_t EXIT2_DR = 4'h0;
  localparam tap_state_t UPD_DR   = 4'h5;
  localparam tap_state_t SEL_IR   = 4'h4;
  localparam tap_state_t CAP_IR   = 4'hE;
  localparam tap_state_t SHIFT_IR = 4'hA;
  localparam tap_state_t EXIT1_IR = 4'h9;
  localparam tap_state_t PAUSE_IR = 4'hB;
  localparam tap_state_t EXIT2_IR = 4'h8;
  localparam tap_state_t UPD_IR   = 4'hD;

  typedef struct packed {
    logic tlr;
    logic cap_dr;
    logic shift_dr;
    logic upd_dr;
    logic cap_ir;
    logic shift_ir;
    logic upd_ir;
  } tap_dec_t;

endpackage

// File: rtl/jtag_tap_controller_if.sv
// JTAG pin and boundary-scan chain signals; slave is the TAP side, master the
// pins/chain side.
interface jtag_tap_controller_if;

  logic       TMS;
  logic       TDI;
  logic       TDO;
  logic       TDO_en;
  logic       FromBSChain;
  logic       CaptureDR;
  logic       ShiftDR;
  logic       UpdateDR;
  logic       TestMode;
  logic [3:0] TapState;

  modport slave (
    input  TMS, TDI, FromBSChain,
    output TDO, TDO_en, CaptureDR, ShiftDR, UpdateDR, TestMode, TapState
  );

  modport master (
    output TMS, TDI, FromBSChain,
    input  TDO, TDO_en, CaptureDR, ShiftDR, UpdateDR, TestMode, TapState
  );

endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP sequencer driven by TMS, plus Moore decodes of the state register.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       tms_i,
  output tap_state_t state_o,
  output tap_dec_t   dec_c_o
);

  tap_state_t state_q;
  tap_state_t state_d;

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    dec_c_o          = '0;
    dec_c_o.tlr      = (state_q == TLR);
    dec_c_o.cap_dr   = (state_q == CAP_DR);
    dec_c_o.shift_dr = (state_q == SHIFT_DR);
    dec_c_o.upd_dr   = (state_q == UPD_DR);
    dec_c_o.cap_ir   = (state_q == CAP_IR);
    dec_c_o.shift_ir = (state_q == SHIFT_IR);
    dec_c_o.upd_ir   = (state_q == UPD_IR);
    case (state_q)
      TLR:      state_d = tms_i ? TLR      : RTI;
      RTI:      state_d = tms_i ? SEL_DR   : RTI;
      SEL_DR:   state_d = tms_i ? SEL_IR   : CAP_DR;
      CAP_DR:   state_d = tms_i ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: state_d = tms_i ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: state_d = tms_i ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_d = tms_i ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: state_d = tms_i ? UPD_DR   : SHIFT_DR;
      UPD_DR:   state_d = tms_i ? SEL_DR   : RTI;
      SEL_IR:   state_d = tms_i ? TLR      : CAP_IR;
      CAP_IR:   state_d = tms_i ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: state_d = tms_i ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: state_d = tms_i ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_d = tms_i ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: state_d = tms_i ? UPD_IR   : SHIFT_IR;
      UPD_IR:   state_d = tms_i ? SEL_DR   : RTI;
      default:  state_d = TLR;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1-style TAP: instruction register, BYPASS/IDCODE data registers,
// boundary-scan chain strobes and the negedge TDO mux.
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter int unsigned          IR_WIDTH     = DEF_IR_WIDTH,
  parameter logic [IDCODE_W-1:0]  IDCODE_VALUE = DEF_IDCODE,
  parameter logic [IR_WIDTH-1:0]  OP_EXTEST    = IR_WIDTH'(DEF_OP_EXTEST),
  parameter logic [IR_WIDTH-1:0]  OP_SAMPLE    = IR_WIDTH'(DEF_OP_SAMPLE),
  parameter logic [IR_WIDTH-1:0]  OP_IDCODE    = IR_WIDTH'(DEF_OP_IDCODE),
  parameter logic [IR_WIDTH-1:0]  OP_BYPASS    = IR_WIDTH'(DEF_OP_BYPASS)
) (
  input  logic                  TCK,
  input  logic                  TRST,
  jtag_tap_controller_if.slave  jtag
);

  tap_state_t state;
  tap_dec_t   dec;

  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic [IDCODE_W-1:0] id_sr_q, id_sr_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;
  logic                sel_bs_c, sel_id_c, dr_lsb_c;

  jtag_tap_fsm u_fsm (
    .TCK     (TCK),
    .TRST    (TRST),
    .tms_i   (jtag.TMS),
    .state_o (state),
    .dec_c_o (dec)
  );

  // BYPASS opcode and every undefined opcode fall through to the 1-bit bypass.
  assign sel_bs_c = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE);
  assign sel_id_c = (ir_q == OP_IDCODE) && (ir_q != OP_BYPASS);
  assign dr_lsb_c = sel_bs_c ? jtag.FromBSChain : (sel_id_c ? id_sr_q[0] : bypass_q);

  always_comb begin
    ir_d     = ir_q;
    ir_sr_d  = ir_sr_q;
    id_sr_d  = id_sr_q;
    bypass_d = bypass_q;
    if (dec.tlr) begin
      ir_d     = OP_IDCODE;
      id_sr_d  = IDCODE_VALUE;
      bypass_d = 1'b0;
    end
    if (dec.cap_ir)   ir_sr_d = IR_WIDTH'(2'b01);
    if (dec.shift_ir) ir_sr_d = {jtag.TDI, ir_sr_q[IR_WIDTH-1:1]};
    if (dec.upd_ir)   ir_d    = ir_sr_q;
    if (dec.cap_dr) begin
      if (sel_id_c)       id_sr_d  = IDCODE_VALUE;
      else if (!sel_bs_c) bypass_d = 1'b0;
    end
    if (dec.shift_dr) begin
      if (sel_id_c)       id_sr_d  = {jtag.TDI, id_sr_q[IDCODE_W-1:1]};
      else if (!sel_bs_c) bypass_d = jtag.TDI;
    end
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_q     <= OP_IDCODE;
      ir_sr_q  <= '0;
      id_sr_q  <= IDCODE_VALUE;
      bypass_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      ir_sr_q  <= ir_sr_d;
      id_sr_q  <= id_sr_d;
      bypass_q <= bypass_d;
    end
  end

  // TDO launches on the falling edge so the host samples it on the next rise.
  always_comb begin
    tdo_en_d = dec.shift_ir | dec.shift_dr;
    tdo_d    = 1'b0;
    if (dec.shift_ir)      tdo_d = ir_sr_q[0];
    else if (dec.shift_dr) tdo_d = dr_lsb_c;
  end

  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign jtag.TDO       = tdo_q;
  assign jtag.TDO_en    = tdo_en_q;
  assign jtag.CaptureDR = sel_bs_c & dec.cap_dr;
  assign jtag.ShiftDR   = sel_bs_c & dec.shift_dr;
  assign jtag.UpdateDR  = sel_bs_c & dec.upd_dr;
  assign jtag.TestMode  = (ir_q == OP_EXTEST) & ~dec.tlr;
  assign jtag.TapState  = state;

endmodule
